// File: rtl/reg_writeback_queue.sv
// Writeback queue between the WB stage and the register bank: buffers writes, drains one per cycle.
// Define RWQ_FORWARD_EN to add the combinational forwarding lookup over queued entries.
module reg_writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_jal,
  input  logic [31:0]              in_pc,
  input  logic                     wb_stall,
  output logic                     wb_we,
  output logic [ADDR_W-1:0]        wb_reg,
  output logic [DATA_W-1:0]        wb_data,
  input  logic [ADDR_W-1:0]        fwd_reg1,
  input  logic [ADDR_W-1:0]        fwd_reg2,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] LinkReg = ADDR_W'(31);

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              empty, store, pop;
  logic [ADDR_W-1:0] push_reg;
  logic [DATA_W-1:0] push_data;
  logic [31:0]       pc_plus1;

  assign empty    = (count_q == '0);
  // Full stays full for the whole cycle, even if the head pops on the same edge.
  assign in_ready = (count_q != CntW'(DEPTH));
  // Writes to r0 complete the handshake but are dropped; jal always targets r31.
  assign store    = in_valid & in_ready & (in_jal | (in_reg != '0));
  assign pc_plus1 = in_pc + 32'd1;
  assign push_reg  = in_jal ? LinkReg : in_reg;
  assign push_data = in_jal ? DATA_W'(pc_plus1) : in_data;

  assign wb_we   = ~empty & ~wb_stall;
  assign wb_reg  = empty ? '0 : reg_q[rd_ptr_q];
  assign wb_data = empty ? '0 : data_q[rd_ptr_q];
  assign pop     = wb_we;
  assign count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (store) begin
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    unique case ({store, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; valid bits and count guard every read.
  always_ff @(posedge clock) begin
    if (store) begin
      reg_q[wr_ptr_q]  <= push_reg;
      data_q[wr_ptr_q] <= push_data;
    end
  end

`ifdef RWQ_FORWARD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (valid_q[idx] && (fwd_reg1 != '0) && (reg_q[idx] == fwd_reg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if (valid_q[idx] && (fwd_reg2 != '0) && (reg_q[idx] == fwd_reg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data2 = '0;

  logic unused_fwd;
  assign unused_fwd = ^{fwd_reg1, fwd_reg2, valid_q};
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue; forwarding expectations follow RWQ_FORWARD_EN.
module tb_reg_writeback_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_jal, wb_stall, wb_we;
  logic [4:0]  in_reg, wb_reg, fwd_reg1, fwd_reg2;
  logic [31:0] in_data, in_pc, wb_data, fwd_data1, fwd_data2;
  logic        fwd_hit1, fwd_hit2;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

`ifdef RWQ_FORWARD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .in_jal    (in_jal),
    .in_pc     (in_pc),
    .wb_stall  (wb_stall),
    .wb_we     (wb_we),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .fwd_reg1  (fwd_reg1),
    .fwd_reg2  (fwd_reg2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_jal   = 1'b0;
    in_reg   = r;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    in_jal   = 1'b0;
    in_pc    = '0;
    wb_stall = 1'b0;
    fwd_reg1 = '0;
    fwd_reg2 = '0;
    #12;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_we", 32'(wb_we), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_hit1", 32'(fwd_hit1), 32'd0);
    check_eq("rst_fdata1", fwd_data1, 32'd0);
    check_eq("rst_wbreg", 32'(wb_reg), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: single write appears the cycle after the push, then queue empties.
    push(5'd5, 32'h1234);
    check_eq("t1_we", 32'(wb_we), 32'd1);
    check_eq("t1_reg", 32'(wb_reg), 32'd5);
    check_eq("t1_data", wb_data, 32'h1234);
    check_eq("t1_count", 32'(count), 32'd1);
    tick();
    check_eq("t1_empty_we", 32'(wb_we), 32'd0);
    check_eq("t1_empty_cnt", 32'(count), 32'd0);
    check_eq("t1_empty_data", wb_data, 32'd0);

    // 2: fill under stall, hold a 5th request, then drain in order.
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
    check_eq("t2_full_cnt", 32'(count), 32'd4);
    check_eq("t2_full_rdy", 32'(in_ready), 32'd0);
    check_eq("t2_stall_we", 32'(wb_we), 32'd0);
    check_eq("t2_stall_reg", 32'(wb_reg), 32'd1);
    in_valid = 1'b1;
    in_reg   = 5'd5;
    in_data  = 32'h105;
    tick();
    check_eq("t2_held_cnt", 32'(count), 32'd4);
    wb_stall = 1'b0;
    #1;
    check_eq("t2_pop_we", 32'(wb_we), 32'd1);
    check_eq("t2_pop_rdy", 32'(in_ready), 32'd0);
    check_eq("t2_pop_reg1", 32'(wb_reg), 32'd1);
    tick();
    check_eq("t2_rdy_after", 32'(in_ready), 32'd1);
    check_eq("t2_cnt3", 32'(count), 32'd3);
    check_eq("t2_reg2", 32'(wb_reg), 32'd2);
    tick();
    in_valid = 1'b0;
    #1;
    check_eq("t2_pushpop_cnt", 32'(count), 32'd3);
    check_eq("t2_reg3", 32'(wb_reg), 32'd3);
    check_eq("t2_data3", wb_data, 32'h103);
    tick();
    check_eq("t2_reg4", 32'(wb_reg), 32'd4);
    tick();
    check_eq("t2_reg5", 32'(wb_reg), 32'd5);
    check_eq("t2_data5", wb_data, 32'h105);
    tick();
    check_eq("t2_done_cnt", 32'(count), 32'd0);
    check_eq("t2_done_we", 32'(wb_we), 32'd0);

    // 3: jal link write, plus PC wraparound.
    in_valid = 1'b1;
    in_jal   = 1'b1;
    in_pc    = 32'h40;
    in_reg   = 5'd7;
    in_data  = 32'hFFFF;
    tick();
    in_pc = 32'hFFFF_FFFF;
    #1;
    check_eq("t3_reg", 32'(wb_reg), 32'd31);
    check_eq("t3_data", wb_data, 32'h41);
    tick();
    in_valid = 1'b0;
    in_jal   = 1'b0;
    #1;
    check_eq("t3_wrap_reg", 32'(wb_reg), 32'd31);
    check_eq("t3_wrap_data", wb_data, 32'd0);
    tick();
    check_eq("t3_empty", 32'(count), 32'd0);

    // 4: writes to r0 are accepted but dropped.
    check_eq("t4_ready", 32'(in_ready), 32'd1);
    push(5'd0, 32'hDEAD);
    check_eq("t4_cnt", 32'(count), 32'd0);
    check_eq("t4_we", 32'(wb_we), 32'd0);
    tick();
    check_eq("t4_we_later", 32'(wb_we), 32'd0);

    // 5: forwarding picks the youngest match; index 0 never hits.
    wb_stall = 1'b1;
    push(5'd9, 32'h11);
    push(5'd9, 32'h22);
    push(5'd3, 32'h33);
    fwd_reg1 = 5'd9;
    fwd_reg2 = 5'd0;
    #1;
    check_eq("t5_cnt", 32'(count), 32'd3);
    check_eq("t5_head", wb_data, 32'h11);
    check_eq("t5_hit1", 32'(fwd_hit1), FwdOn ? 32'd1 : 32'd0);
    check_eq("t5_data1", fwd_data1, FwdOn ? 32'h22 : 32'd0);
    check_eq("t5_hit2_r0", 32'(fwd_hit2), 32'd0);
    fwd_reg2 = 5'd3;
    #1;
    check_eq("t5_hit2", 32'(fwd_hit2), FwdOn ? 32'd1 : 32'd0);
    check_eq("t5_data2", fwd_data2, FwdOn ? 32'h33 : 32'd0);
    fwd_reg2 = 5'd4;
    #1;
    check_eq("t5_miss", 32'(fwd_hit2), 32'd0);

    // 6: asynchronous reset mid-cycle flushes the queue immediately.
    wb_stall = 1'b0;
    #1;
    check_eq("t6_we_pre", 32'(wb_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_cnt", 32'(count), 32'd0);
    check_eq("t6_we", 32'(wb_we), 32'd0);
    check_eq("t6_hit1", 32'(fwd_hit1), 32'd0);
    check_eq("t6_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_eq("t6_after_cnt", 32'(count), 32'd0);
    check_eq("t6_after_we", 32'(wb_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
